// File: rtl/byte_packer32.sv
// byte_packer32: packs a valid/ready byte stream into 32-bit words and presents each word with a
// one-cycle load strobe the cycle after its last byte; input is held off only while a stalled word is pending.
module byte_packer32 #(
  parameter bit         LSB_FIRST = 1'b1,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_last,
  output logic        o_in_ready,
  input  logic        i_stall,
  output logic        o_load,
  output logic [31:0] o_d,
  output logic [2:0]  o_word_bytes
);

  logic [31:0] r_acc;
  logic [1:0]  r_cnt;
  logic [31:0] r_d;
  logic [2:0]  r_word_bytes;
  logic        r_out_valid;

  logic        w_load;
  logic        w_ready;
  logic        w_accept;
  logic        w_complete;
  logic [1:0]  w_lane;
  logic [31:0] w_acc_next;
  logic [31:0] w_word;

  assign w_load     = r_out_valid & ~i_stall;
  assign w_ready    = ~r_out_valid | ~i_stall;
  assign w_accept   = i_in_valid & w_ready;
  assign w_complete = w_accept & ((r_cnt == 2'd3) | i_in_last);
  assign w_lane     = LSB_FIRST ? r_cnt : (2'd3 - r_cnt);

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{w_lane, 3'b000} +: 8] = i_in_data;
  end

  // Lanes beyond the incoming byte are forced to PAD_BYTE so a flushed word never exposes stale bytes.
  for (genvar j = 0; j < 4; j++) begin : g_lane
    localparam logic [1:0] K = LSB_FIRST ? 2'(j) : 2'(3 - j);
    assign w_word[8*j +: 8] = (K <= r_cnt) ? w_acc_next[8*j +: 8] : PAD_BYTE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc        <= 32'h0;
      r_cnt        <= 2'd0;
      r_d          <= 32'h0;
      r_word_bytes <= 3'd0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid  <= 1'b0;
        r_word_bytes <= 3'd0;
      end
      // A completion on the same edge as a drain overrides it, giving back-to-back words.
      if (w_accept) begin
        if (w_complete) begin
          r_d          <= w_word;
          r_word_bytes <= {1'b0, r_cnt} + 3'd1;
          r_out_valid  <= 1'b1;
          r_acc        <= {4{PAD_BYTE}};
          r_cnt        <= 2'd0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign o_in_ready   = w_ready;
  assign o_load       = w_load;
  assign o_d          = r_d;
  assign o_word_bytes = r_word_bytes;

endmodule

// File: tb/tb_byte_packer32.sv
// Bench for byte_packer32: two instances (LSB-first/pad 00 and MSB-first/pad A5) share one stimulus stream
// and are checked every cycle against a queue-based word model, plus literal expectations on directed patterns.
module tb_byte_packer32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       stall;

  logic        rdy1, load1, rdy0, load0;
  logic [31:0] d1, d0;
  logic [2:0]  wb1, wb0;

  byte_packer32 #(.LSB_FIRST(1'b1), .PAD_BYTE(8'h00)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .i_in_last(in_last), .o_in_ready(rdy1), .i_stall(stall), .o_load(load1),
    .o_d(d1), .o_word_bytes(wb1));

  byte_packer32 #(.LSB_FIRST(1'b0), .PAD_BYTE(8'hA5)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .i_in_last(in_last), .o_in_ready(rdy0), .i_stall(stall), .o_load(load0),
    .o_d(d0), .o_word_bytes(wb0));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  bit chk_en  = 1'b0;

  // Reference model: bytes of the word being built, plus the word held for the consumer.
  logic [7:0]  part[$];
  bit          m_vld = 1'b0;
  int          m_n   = 0;
  logic [31:0] m_d1  = 32'h0;
  logic [31:0] m_d0  = 32'h0;

  // Log of words the DUTs actually delivered, for the directed checks.
  logic [31:0] log_d1[$];
  logic [31:0] log_d0[$];
  int          log_n[$];
  int          log_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) begin
    cycle++;
    if (!rst_n) begin
      part.delete();
      m_vld = 1'b0;
      m_n   = 0;
      m_d1  = 32'h0;
      m_d0  = 32'h0;
    end else begin
      bit ready, take;
      ready = !m_vld || !stall;
      take  = in_valid && ready;
      if (m_vld && !stall) m_vld = 1'b0;
      if (take) begin
        part.push_back(in_data);
        if (part.size() == 4 || in_last) begin
          m_n  = part.size();
          m_d1 = 32'h0;
          m_d0 = 32'h0;
          for (int k = 0; k < 4; k++) begin
            logic [7:0] b1, b0;
            b1 = (k < m_n) ? part[k] : 8'h00;
            b0 = (k < m_n) ? part[k] : 8'hA5;
            m_d1 = m_d1 | (32'(b1) << (8 * k));
            m_d0 = m_d0 | (32'(b0) << (8 * (3 - k)));
          end
          m_vld = 1'b1;
          part.delete();
        end
      end
      if (!m_vld) m_n = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready1", 32'(rdy1), 32'(!m_vld || !stall));
      check("in_ready0", 32'(rdy0), 32'(!m_vld || !stall));
      check("load1", 32'(load1), 32'(m_vld && !stall));
      check("load0", 32'(load0), 32'(m_vld && !stall));
      check("d1", d1, m_d1);
      check("d0", d0, m_d0);
      check("word_bytes1", 32'(wb1), 32'(m_n));
      check("word_bytes0", 32'(wb0), 32'(m_n));
    end
    if (load1) begin
      log_d1.push_back(d1);
      log_d0.push_back(d0);
      log_n.push_back(int'(wb1));
      log_cyc.push_back(cycle);
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] b, input logic l);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_log();
    log_d1.delete();
    log_d0.delete();
    log_n.delete();
    log_cyc.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset load", 32'(load1), 32'h0);
    check("reset in_ready", 32'(rdy1), 32'h1);
    check("reset d", d1, 32'h0);
    check("reset word_bytes", 32'(wb0), 32'h0);
    @(posedge clk); #1;

    // Fill
    clear_log();
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0);
    idle(3);
    check("fill count", log_d1.size(), 1);
    if (log_d1.size() == 1) begin
      check("fill d lsb", log_d1[0], 32'h44332211);
      check("fill d msb", log_d0[0], 32'h11223344);
      check("fill bytes", log_n[0], 4);
    end

    // Flush of a partial word, then a 1-byte word starting in lane 0
    clear_log();
    put(8'hAA, 0); put(8'hBB, 1);
    idle(2);
    put(8'hCC, 1);
    idle(2);
    check("flush count", log_d1.size(), 2);
    if (log_d1.size() == 2) begin
      check("flush d lsb", log_d1[0], 32'h0000BBAA);
      check("flush d msb", log_d0[0], 32'hAABBA5A5);
      check("flush bytes", log_n[0], 2);
      check("flush1 d lsb", log_d1[1], 32'h000000CC);
      check("flush1 d msb", log_d0[1], 32'hCCA5A5A5);
      check("flush1 bytes", log_n[1], 1);
    end

    // Stall hold
    clear_log();
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
    stall = 1'b1;
    put(8'h44, 0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("stall in_ready", 32'(rdy1), 32'h0);
      check("stall load", 32'(load1), 32'h0);
      check("stall d", d1, 32'h44332211);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check("release load", 32'(load1), 32'h1);
    check("release in_ready", 32'(rdy1), 32'h1);
    @(posedge clk); #1;
    put(8'h66, 1);
    idle(2);
    check("stall count", log_d1.size(), 2);
    if (log_d1.size() == 2) begin
      check("stall word", log_d1[0], 32'h44332211);
      check("after stall word", log_d1[1], 32'h00006655);
    end

    // Back-to-back
    clear_log();
    for (int i = 1; i <= 8; i++) put(8'(i), 0);
    idle(3);
    check("b2b count", log_d1.size(), 2);
    if (log_d1.size() == 2) begin
      check("b2b word0", log_d1[0], 32'h04030201);
      check("b2b word1", log_d1[1], 32'h08070605);
      check("b2b spacing", log_cyc[1] - log_cyc[0], 4);
    end

    // Reset mid-word
    clear_log();
    put(8'hE1, 0); put(8'hE2, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    put(8'hC1, 0); put(8'hC2, 0); put(8'hC3, 0); put(8'hC4, 0);
    idle(3);
    check("reset count", log_d1.size(), 1);
    if (log_d1.size() == 1) begin
      check("reset word", log_d1[0], 32'hC4C3C2C1);
      check("reset bytes", log_n[0], 4);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom_range(9) < 7);
      in_data  = 8'($urandom);
      in_last  = ($urandom_range(4) == 0);
      stall    = ($urandom_range(9) < 3);
      if (c == 2500) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b1; stall = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
